// File: rtl/rom_fetch_scheduler_pkg.sv
// Shared constants, FSM encoding and helpers for the ROM fetch scheduler.
package fetch_pkg;

   localparam int LANES  = 12;
   localparam int LANE_W = 4;
   localparam int ADDR_W = 10;
   localparam int CNT_W  = ADDR_W + 1;

   typedef enum logic {S_IDLE, S_RUN} state_e;

   function automatic logic [LANES-1:0] onehot(input logic [LANE_W-1:0] lane);
      return LANES'(1) << lane;
   endfunction

endpackage

// File: rtl/rom_fetch_scheduler_if.sv
// Config, control and FIFO/ROM side signals of the fetch scheduler.
interface rom_fetch_scheduler_if;
   import fetch_pkg::*;

   logic              cfg_we;
   logic [LANE_W-1:0] cfg_lane;
   logic [ADDR_W-1:0] cfg_base;
   logic [CNT_W-1:0]  cfg_len;
   logic              start;
   logic              abort;
   logic [LANES-1:0]  fifo_full;
   logic [ADDR_W-1:0] rom_addr;
   logic [LANES-1:0]  fifo_wr_en;
   logic              busy;
   logic              done;

   modport master (
      output cfg_we, cfg_lane, cfg_base, cfg_len, start, abort, fifo_full,
      input  rom_addr, fifo_wr_en, busy, done
   );

   modport slave (
      input  cfg_we, cfg_lane, cfg_base, cfg_len, start, abort, fifo_full,
      output rom_addr, fifo_wr_en, busy, done
   );

endinterface

// File: rtl/rom_fetch_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr_i, wrapping.
module rr_arbiter #(
   parameter int N = 12,
   parameter int W = 4
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic         grant_valid_o,
   output logic [W-1:0] grant_idx_o
);

   int idx;

   // Scan farthest-first so the nearest requester after the pointer wins.
   always_comb begin
      grant_valid_o = 1'b0;
      grant_idx_o   = '0;
      idx           = 0;
      for (int off = N; off >= 1; off--) begin
         idx = (int'(ptr_i) + off) % N;
         if (req_i[idx]) begin
            grant_valid_o = 1'b1;
            grant_idx_o   = W'(idx);
         end
      end
   end

endmodule

// File: rtl/rom_fetch_scheduler.sv
// Shares one async-read ROM port among the lane fetch FIFOs, one word per grant.
module rom_fetch_scheduler
   import fetch_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   rom_fetch_scheduler_if.slave bus
);

   state_e            state_q;
   logic [ADDR_W-1:0] base_q [LANES];
   logic [CNT_W-1:0]  len_q  [LANES];
   logic [CNT_W-1:0]  rem_q  [LANES];
   logic [ADDR_W-1:0] off_q  [LANES];
   logic [LANE_W-1:0] rr_q;
   logic [ADDR_W-1:0] rom_addr_q;
   logic [LANES-1:0]  wr_en_q;
   logic              busy_q;
   logic              done_q;

   logic [LANES-1:0]  elig;
   logic              all_len_zero;
   logic              all_rem_zero;
   logic              cfg_ok;
   logic              gnt_vld;
   logic [LANE_W-1:0] gnt_idx;
   logic [ADDR_W-1:0] addr_d;
   logic [LANES-1:0]  wr_en_d;

   assign cfg_ok = int'(bus.cfg_lane) < LANES;

   // A lane written last cycle is excluded: its full flag has not caught up yet.
   always_comb begin
      elig         = '0;
      all_len_zero = 1'b1;
      all_rem_zero = 1'b1;
      for (int i = 0; i < LANES; i++) begin
         elig[i] = (state_q == S_RUN) && (rem_q[i] != '0) &&
                   !bus.fifo_full[i] && !wr_en_q[i];
         if (len_q[i] != '0) all_len_zero = 1'b0;
         if (rem_q[i] != '0) all_rem_zero = 1'b0;
      end
   end

   rr_arbiter #(.N(LANES), .W(LANE_W)) u_arb (
      .req_i         (elig),
      .ptr_i         (rr_q),
      .grant_valid_o (gnt_vld),
      .grant_idx_o   (gnt_idx)
   );

   assign addr_d  = base_q[gnt_idx] + off_q[gnt_idx];
   assign wr_en_d = onehot(gnt_idx);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rr_q       <= LANE_W'(LANES - 1);
         rom_addr_q <= '0;
         wr_en_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         for (int i = 0; i < LANES; i++) begin
            base_q[i] <= '0;
            len_q[i]  <= '0;
            rem_q[i]  <= '0;
            off_q[i]  <= '0;
         end
      end else begin
         done_q <= 1'b0;
         if (bus.abort) begin
            state_q <= S_IDLE;
            wr_en_q <= '0;
            busy_q  <= 1'b0;
            for (int i = 0; i < LANES; i++) rem_q[i] <= '0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  wr_en_q <= '0;
                  if (bus.cfg_we && cfg_ok) begin
                     base_q[bus.cfg_lane] <= bus.cfg_base;
                     len_q[bus.cfg_lane]  <= bus.cfg_len;
                  end
                  if (bus.start) begin
                     for (int i = 0; i < LANES; i++) begin
                        rem_q[i] <= len_q[i];
                        off_q[i] <= '0;
                     end
                     if (all_len_zero) begin
                        done_q <= 1'b1;
                     end else begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                     end
                  end
               end
               S_RUN: begin
                  // Nothing left once the last grant is in flight; its write finishes this cycle.
                  if (all_rem_zero) begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     wr_en_q <= '0;
                  end else if (gnt_vld) begin
                     rom_addr_q      <= addr_d;
                     wr_en_q         <= wr_en_d;
                     off_q[gnt_idx]  <= off_q[gnt_idx] + ADDR_W'(1);
                     rem_q[gnt_idx]  <= rem_q[gnt_idx] - CNT_W'(1);
                     rr_q            <= gnt_idx;
                  end else begin
                     wr_en_q <= '0;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.rom_addr   = rom_addr_q;
   assign bus.fifo_wr_en = wr_en_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_rom_fetch_scheduler.sv
// Bench for rom_fetch_scheduler: behavioural model, per-cycle compare, directed and random runs.
module tb_rom_fetch_scheduler;
   import fetch_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rom_fetch_scheduler_if bus();
   rom_fetch_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int done_cyc = -1;

   typedef struct {int lane; int addr; int cyc;} wr_t;
   wr_t wq[$];

   // Model: per-lane programme and progress, last granted lane, expected outputs.
   int   m_run;
   int   m_base[LANES];
   int   m_len[LANES];
   int   m_rem[LANES];
   int   m_off[LANES];
   int   m_rr;
   int   m_wr;
   int   e_addr;
   logic e_busy;
   logic e_done;

   task automatic chk(string nm, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_run = 0; m_rr = LANES - 1; m_wr = -1;
         e_addr = 0; e_busy = 1'b0; e_done = 1'b0;
         for (int i = 0; i < LANES; i++) begin
            m_base[i] = 0; m_len[i] = 0; m_rem[i] = 0; m_off[i] = 0;
         end
      end else begin
         int total;
         int g;
         e_done = 1'b0;
         total = 0;
         g = -1;
         if (bus.abort) begin
            m_run = 0; m_wr = -1; e_busy = 1'b0;
            for (int i = 0; i < LANES; i++) m_rem[i] = 0;
         end else if (m_run == 0) begin
            m_wr = -1;
            if (bus.start) begin
               for (int i = 0; i < LANES; i++) begin
                  m_rem[i] = m_len[i]; m_off[i] = 0; total += m_len[i];
               end
               if (total == 0) e_done = 1'b1;
               else begin m_run = 1; e_busy = 1'b1; end
            end
            if (bus.cfg_we && int'(bus.cfg_lane) < LANES) begin
               m_base[int'(bus.cfg_lane)] = int'(bus.cfg_base);
               m_len[int'(bus.cfg_lane)]  = int'(bus.cfg_len);
            end
         end else begin
            for (int i = 0; i < LANES; i++) total += m_rem[i];
            if (total == 0) begin
               m_run = 0; e_busy = 1'b0; e_done = 1'b1; m_wr = -1;
            end else begin
               for (int k = 1; k <= LANES; k++) begin
                  int i;
                  i = (m_rr + k) % LANES;
                  if (g < 0 && m_rem[i] > 0 && !bus.fifo_full[i] && m_wr != i) g = i;
               end
               if (g >= 0) begin
                  e_addr = (m_base[g] + m_off[g]) % (1 << ADDR_W);
                  m_off[g]++; m_rem[g]--; m_rr = g; m_wr = g;
               end else m_wr = -1;
            end
         end
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         chk("rom_addr", int'(bus.rom_addr), e_addr);
         chk("fifo_wr_en", int'(bus.fifo_wr_en), (m_wr < 0) ? 0 : (1 << m_wr));
         chk("busy", int'(bus.busy), int'(e_busy));
         chk("done", int'(bus.done), int'(e_done));
         for (int i = 0; i < LANES; i++)
            if (bus.fifo_wr_en[i]) wq.push_back('{i, int'(bus.rom_addr), cyc});
         if (bus.done) done_cyc = cyc;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.cfg_we = 1'b0; bus.cfg_lane = '0; bus.cfg_base = '0; bus.cfg_len = '0;
      bus.start = 1'b0; bus.abort = 1'b0; bus.fifo_full = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic cfg(int l, int b, int n);
      bus.cfg_we = 1'b1; bus.cfg_lane = LANE_W'(l);
      bus.cfg_base = ADDR_W'(b); bus.cfg_len = CNT_W'(n);
      tick();
      bus.cfg_we = 1'b0;
   endtask

   task automatic go();
      wq.delete();
      done_cyc = -1;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_idle(string nm, int budget);
      int k;
      k = 0;
      while (m_run != 0 && k < budget) begin tick(); k++; end
      chk({nm, "_timeout"}, m_run, 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n1;
      int rel;
      int la[];
      int aa[];
      idle_inputs();
      tick(); tick();
      chk("rst_rom_addr", int'(bus.rom_addr), 0);
      chk("rst_wr_en", int'(bus.fifo_wr_en), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      rst = 1'b0;
      tick();

      // Two lanes interleave; an out-of-range lane write is ignored.
      cfg(0, 'h000, 3); cfg(1, 'h100, 2); cfg(14, 'h3, 5);
      go(); wait_idle("t1", 50);
      la = '{0, 1, 0, 1, 0};
      aa = '{'h000, 'h100, 'h001, 'h101, 'h002};
      chk("t1_count", wq.size(), 5);
      for (int i = 0; i < 5 && i < wq.size(); i++) begin
         chk("t1_lane", wq[i].lane, la[i]);
         chk("t1_addr", wq[i].addr, aa[i]);
      end
      if (wq.size() > 0) chk("t1_done_cyc", done_cyc, wq[wq.size()-1].cyc + 1);
      tick();
      chk("t1_busy_after", int'(bus.busy), 0);

      // Single lane wraps the address space and is limited to every other cycle.
      do_reset();
      cfg(5, 'h3FE, 4);
      go(); wait_idle("t2", 50);
      aa = '{'h3FE, 'h3FF, 'h000, 'h001};
      chk("t2_count", wq.size(), 4);
      for (int i = 0; i < 4 && i < wq.size(); i++) begin
         chk("t2_lane", wq[i].lane, 5);
         chk("t2_addr", wq[i].addr, aa[i]);
         if (i > 0) chk("t2_gap", wq[i].cyc - wq[i-1].cyc, 2);
      end
      if (wq.size() > 0) chk("t2_done_cyc", done_cyc, wq[wq.size()-1].cyc + 1);

      // Lane 1 held full for 10 cycles; lanes 0 and 2 proceed, lane 1 catches up afterwards.
      do_reset();
      cfg(0, 'h010, 4); cfg(1, 'h020, 4); cfg(2, 'h030, 4);
      bus.fifo_full = LANES'(2);
      go();
      repeat (9) tick();
      bus.fifo_full = '0;
      rel = cyc;
      wait_idle("t3", 60);
      la = '{0, 2, 0, 2, 0, 2, 0, 2, 1, 1, 1, 1};
      chk("t3_count", wq.size(), 12);
      for (int i = 0; i < 12 && i < wq.size(); i++) begin
         chk("t3_lane", wq[i].lane, la[i]);
         if (wq[i].lane == 1) chk("t3_lane1_after_release", int'(wq[i].cyc > rel), 1);
      end
      if (wq.size() > 0) chk("t3_done_cyc", done_cyc, wq[wq.size()-1].cyc + 1);

      // All lanes, two words each: full rate, strict round robin.
      do_reset();
      for (int i = 0; i < LANES; i++) cfg(i, i * 'h20, 2);
      go(); wait_idle("t4", 80);
      chk("t4_count", wq.size(), 24);
      for (int k = 0; k < 24 && k < wq.size(); k++) begin
         chk("t4_lane", wq[k].lane, k % 12);
         chk("t4_addr", wq[k].addr, (k % 12) * 'h20 + k / 12);
         chk("t4_cyc", wq[k].cyc, wq[0].cyc + k);
      end
      if (wq.size() > 0) chk("t4_done_cyc", done_cyc, wq[0].cyc + 24);

      // Abort after three writes, then restart from offset zero.
      do_reset();
      cfg(0, 'h010, 3); cfg(1, 'h020, 3);
      go();
      n1 = 0;
      while (wq.size() < 3 && n1 < 20) begin tick(); n1++; end
      chk("t5_reach3", int'(wq.size() >= 3), 1);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("t5_abort_wr_en", int'(bus.fifo_wr_en), 0);
      chk("t5_abort_busy", int'(bus.busy), 0);
      chk("t5_abort_done", int'(bus.done), 0);
      tick(); tick();
      chk("t5_no_done", done_cyc, -1);
      go(); wait_idle("t5", 50);
      chk("t5_count", wq.size(), 6);
      n1 = 0;
      rel = 0;
      foreach (wq[i]) begin
         if (wq[i].lane == 0) begin chk("t5_l0_addr", wq[i].addr, 'h010 + n1); n1++; end
         else begin chk("t5_l1_addr", wq[i].addr, 'h020 + rel); rel++; end
      end
      chk("t5_done_seen", int'(done_cyc > 0), 1);
      bus.abort = 1'b1; bus.start = 1'b1;
      tick();
      bus.abort = 1'b0; bus.start = 1'b0;
      chk("t5_abort_beats_start", int'(bus.busy), 0);

      // Every length zero: immediate done, never busy.
      do_reset();
      go();
      chk("t6_done", int'(bus.done), 1);
      chk("t6_busy", int'(bus.busy), 0);
      tick();
      chk("t6_done_pulse", int'(bus.done), 0);

      // Config during RUN is dropped.
      do_reset();
      cfg(3, 'h050, 2);
      go();
      cfg(3, 'h070, 5);
      wait_idle("t7a", 30);
      go(); wait_idle("t7b", 30);
      chk("t7_count", wq.size(), 2);
      for (int i = 0; i < 2 && i < wq.size(); i++) chk("t7_addr", wq[i].addr, 'h050 + i);

      // Async reset mid-RUN clears outputs before any clock edge.
      do_reset();
      cfg(0, 'h055, 8); cfg(1, 'h066, 8);
      go();
      repeat (3) tick();
      chk("t8_busy_pre", int'(bus.busy), 1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t8_async_rom_addr", int'(bus.rom_addr), 0);
      chk("t8_async_wr_en", int'(bus.fifo_wr_en), 0);
      chk("t8_async_busy", int'(bus.busy), 0);
      tick();
      rst = 1'b0;
      tick();

      // Random programmes, random backpressure and occasional aborts.
      for (int r = 0; r < 25; r++) begin
         for (int i = 0; i < LANES; i++)
            if ($urandom_range(1, 0) == 1) cfg(i, int'($urandom_range(1023, 0)), int'($urandom_range(5, 0)));
            else cfg(i, 0, 0);
         cfg(LANES + int'($urandom_range(3, 0)), 'h1, 3);
         go();
         n1 = 0;
         while (m_run != 0 && n1 < 400) begin
            for (int i = 0; i < LANES; i++) bus.fifo_full[i] = ($urandom_range(3, 0) == 0);
            bus.abort = ($urandom_range(99, 0) == 0);
            bus.cfg_we = ($urandom_range(7, 0) == 0);
            bus.cfg_lane = LANE_W'($urandom_range(11, 0));
            bus.cfg_len = CNT_W'($urandom_range(7, 0));
            tick();
            n1++;
         end
         idle_inputs();
         chk("rand_timeout", m_run, 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
